// File: rtl/circular_shift_pipeline.sv
// Pipelined left rotator over SIZE coefficients: modulo-reduction stage, then AMT_W registered rotate-by-2^k stages.
// Optional CIRC_SHIFT_RIGHT_EN adds in_dir for right rotation, mapped onto a left rotation in the reduction stage.

module circular_shift_rot #(
    parameter int SIZE  = 257,
    parameter int WIDTH = 32,
    parameter int SHIFT = 1
) (
    input  logic [SIZE-1:0][WIDTH-1:0] din,
    output logic [SIZE-1:0][WIDTH-1:0] dout
);
    // Fixed wiring per lane: dout[j] takes the element SHIFT positions below it, with wraparound.
    for (genvar j = 0; j < SIZE; j++) begin : g_lane
        assign dout[j] = din[(j + SIZE - SHIFT) % SIZE];
    end
endmodule

module circular_shift_pipeline #(
    parameter int SIZE  = 257,
    parameter int WIDTH = 32,
    parameter int AMT_W = $clog2(SIZE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [AMT_W-1:0]            in_amt,
`ifdef CIRC_SHIFT_RIGHT_EN
    input  logic                        in_dir,
`endif
    input  logic [SIZE-1:0][WIDTH-1:0]  in_list,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [SIZE-1:0][WIDTH-1:0]  out_list
);
    typedef logic [SIZE-1:0][WIDTH-1:0] vec_t;

    localparam logic [AMT_W:0] SIZE_X = (AMT_W+1)'(SIZE);

    vec_t             data_pipe [0:AMT_W];
    logic [AMT_W-1:0] amt_pipe  [0:AMT_W-1];
    logic [AMT_W:0]   vld_pipe;
    vec_t             rot_out   [0:AMT_W-1];

    logic             advance;
    logic [AMT_W:0]   amt_ext;
    logic [AMT_W-1:0] amt_red;
    logic [AMT_W-1:0] amt_eff;

    // A single conditional subtract is enough because 2^AMT_W < 2*SIZE.
    always_comb begin
        amt_ext = {1'b0, in_amt};
        amt_red = (amt_ext >= SIZE_X) ? AMT_W'(amt_ext - SIZE_X) : in_amt;
`ifdef CIRC_SHIFT_RIGHT_EN
        amt_eff = (in_dir && amt_red != '0) ? AMT_W'(SIZE_X - {1'b0, amt_red}) : amt_red;
`else
        amt_eff = amt_red;
`endif
    end

    assign advance   = !vld_pipe[AMT_W] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[AMT_W];
    assign out_list  = data_pipe[AMT_W];

    // Stage k rotates by 2^k mod SIZE; the modulo keeps oversize stages legal.
    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        circular_shift_rot #(
            .SIZE  (SIZE),
            .WIDTH (WIDTH),
            .SHIFT ((1 << k) % SIZE)
        ) u_rot (
            .din  (data_pipe[k]),
            .dout (rot_out[k])
        );
    end

    // Global stall: every register, valid bits included, holds when advance is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int k = 0; k <= AMT_W; k++) data_pipe[k] <= '0;
            for (int k = 0; k < AMT_W; k++)  amt_pipe[k]  <= '0;
        end else if (advance) begin
            vld_pipe     <= {vld_pipe[AMT_W-1:0], in_valid};
            data_pipe[0] <= in_list;
            amt_pipe[0]  <= amt_eff;
            for (int k = 0; k < AMT_W; k++)
                data_pipe[k+1] <= amt_pipe[k][k] ? rot_out[k] : data_pipe[k];
            for (int k = 0; k < AMT_W - 1; k++)
                amt_pipe[k+1] <= amt_pipe[k];
        end
    end
endmodule

// File: tb/tb_circular_shift_pipeline.sv
// Randomised bench for circular_shift_pipeline: a queue scoreboard fed by an arithmetic rotation model.
// Covers reset, latency, streaming, stalls, sparse input, mid-stream reset and (if enabled) right rotation.

module tb_circular_shift_pipeline;
    localparam int SIZE  = 257;
    localparam int WIDTH = 32;
    localparam int AMT_W = 9;
    localparam int LAT   = AMT_W + 1;

    typedef logic [SIZE-1:0][WIDTH-1:0] vec_t;
    typedef struct {
        vec_t v;
        int   cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [AMT_W-1:0] in_amt;
    vec_t             in_list;
    logic             out_valid;
    logic             out_ready;
    vec_t             out_list;
`ifdef CIRC_SHIFT_RIGHT_EN
    logic             in_dir;
`endif

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   n_out = 0;
    int   n_in  = 0;
    bit   chk_lat = 1'b0;
    bit   acc     = 1'b0;

    circular_shift_pipeline #(.SIZE(SIZE), .WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_amt    (in_amt),
`ifdef CIRC_SHIFT_RIGHT_EN
        .in_dir    (in_dir),
`endif
        .in_list   (in_list),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_list  (out_list)
    );

    always #5 clk = ~clk;

    function automatic vec_t ref_rot(vec_t v, int amt, bit right);
        int   r;
        vec_t o;
        r = amt % SIZE;
        for (int i = 0; i < SIZE; i++) begin
            if (!right) o[(i + r) % SIZE] = v[i];
            else        o[i] = v[(i + r) % SIZE];
        end
        return o;
    endfunction

    function automatic vec_t ramp();
        vec_t o;
        for (int i = 0; i < SIZE; i++) o[i] = WIDTH'(i);
        return o;
    endfunction

    function automatic vec_t rand_vec();
        vec_t o;
        for (int i = 0; i < SIZE; i++) o[i] = $urandom;
        return o;
    endfunction

    function automatic int first_diff(vec_t a, vec_t b);
        for (int i = 0; i < SIZE; i++)
            if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: score the handshakes visible now, then advance to just after the next edge.
    task automatic tick();
        exp_t e;
        int   d;
        bit   dir;
        dir = 1'b0;
`ifdef CIRC_SHIFT_RIGHT_EN
        dir = in_dir;
`endif
        #1;
        acc = 1'b0;
        if (!rst) begin
            if (out_valid && out_ready) begin
                tests++;
                assert (q.size() > 0) else begin
                    fails++;
                    $error("FAIL spurious_out: got an output, expected none");
                end
                if (q.size() > 0) begin
                    e = q.pop_front();
                    d = first_diff(out_list, e.v);
                    tests++;
                    assert (d == -1) else begin
                        fails++;
                        $error("FAIL data: lane %0d got %0h expected %0h", d, out_list[d], e.v[d]);
                    end
                    n_out++;
                    if (chk_lat) chk("latency", 32'(cyc - e.cyc), LAT);
                end
            end else if (chk_lat && q.size() > 0 && q[0].cyc + LAT == cyc) begin
                chk("out_valid_due", out_valid, 1'b1);
            end
            if (in_valid && in_ready) begin
                e.v   = ref_rot(in_list, int'(in_amt), dir);
                e.cyc = cyc;
                q.push_back(e);
                acc = 1'b1;
                n_in++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input string tag);
        int w;
        w = 0;
        while (!out_valid && w < 2 * LAT) begin
            tick();
            w++;
        end
        chk(tag, out_valid, 1'b1);
    endtask

    task automatic drain(input string tag);
        int w;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        w = 0;
        while (q.size() > 0 && w < 4 * LAT) begin
            tick();
            w++;
        end
        chk(tag, q.size(), 0);
    endtask

    initial begin
        int   base_in;
        vec_t held;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_amt    = '0;
        in_list   = '0;
        out_ready = 1'b1;
`ifdef CIRC_SHIFT_RIGHT_EN
        in_dir    = 1'b0;
`endif
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        tests++;
        assert (out_list === '0) else begin
            fails++;
            $error("FAIL rst_out_list: got lane0 %0h expected all zero", out_list[0]);
        end

        // Single ramp vector rotated by 1.
        chk_lat  = 1'b1;
        in_list  = ramp();
        in_amt   = 9'd1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid("t1_valid");
        chk("t1_lane0", out_list[0], 32'd256);
        chk("t1_lane1", out_list[1], 32'd0);
        chk("t1_lane256", out_list[256], 32'd255);
        drain("t1_drain");

        // 300 back-to-back vectors, boundary amounts mixed in.
        n_out = 0;
        for (int n = 0; n < 300; n++) begin
            in_valid = 1'b1;
            in_list  = rand_vec();
            case (n)
                3:       in_amt = 9'd257;
                5:       in_amt = 9'd511;
                7:       in_amt = 9'd0;
                9:       in_amt = 9'd256;
                default: in_amt = 9'($urandom_range(0, 511));
            endcase
            tick();
            chk("t2_accept", acc, 1'b1);
        end
        drain("t2_drain");
        chk("t2_count", n_out, 300);

        // Fill, stall five cycles with input held, then resume with simultaneous consume/accept.
        chk_lat  = 1'b0;
        n_out    = 0;
        base_in  = n_in;
        in_valid = 1'b1;
        in_list  = rand_vec();
        in_amt   = 9'($urandom_range(0, 511));
        repeat (12) begin
            tick();
            if (acc) begin
                in_list = rand_vec();
                in_amt  = 9'($urandom_range(0, 511));
            end
        end
        out_ready = 1'b0;
        #1;
        held = out_list;
        for (int n = 0; n < 5; n++) begin
            chk("t3_in_ready", in_ready, 1'b0);
            chk("t3_out_valid", out_valid, 1'b1);
            tests++;
            assert (out_list === held) else begin
                fails++;
                $error("FAIL t3_stable: got lane0 %0h expected %0h", out_list[0], held[0]);
            end
            tick();
            chk("t3_no_accept", acc, 1'b0);
        end
        out_ready = 1'b1;
        repeat (6) begin
            tick();
            chk("t3_resume_accept", acc, 1'b1);
            in_list = rand_vec();
            in_amt  = 9'($urandom_range(0, 511));
        end
        drain("t3_drain");
        chk("t3_count", n_out, n_in - base_in);

        // Sparse 1,0,0,1 input pattern at fixed latency.
        chk_lat = 1'b1;
        for (int n = 0; n < 16; n++) begin
            in_valid = (n % 4 == 0) || (n % 4 == 3);
            in_list  = rand_vec();
            in_amt   = 9'($urandom_range(0, 511));
            tick();
        end
        drain("t4_drain");

        // Reset with six vectors in flight.
        in_valid = 1'b1;
        repeat (6) begin
            in_list = rand_vec();
            in_amt  = 9'($urandom_range(0, 511));
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        chk("t5_out_valid", out_valid, 1'b0);
        chk("t5_in_ready", in_ready, 1'b1);
        repeat (LAT + 2) tick();
        chk("t5_quiet", out_valid, 1'b0);
        in_list  = ramp();
        in_amt   = 9'd256;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid("t5_valid");
        chk("t5_lane256", out_list[256], 32'd0);
        chk("t5_lane0", out_list[0], 32'd1);
        drain("t5_drain");

`ifdef CIRC_SHIFT_RIGHT_EN
        // Right rotation: directed cases, then a random mixed-direction stream.
        in_dir   = 1'b1;
        in_list  = ramp();
        in_amt   = 9'd1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid("t6_valid");
        chk("t6_lane0", out_list[0], 32'd1);
        chk("t6_lane256", out_list[256], 32'd0);
        drain("t6_drain");
        in_amt   = 9'd0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_valid("t6_id_valid");
        chk("t6_id_lane0", out_list[0], 32'd0);
        chk("t6_id_lane256", out_list[256], 32'd256);
        drain("t6_id_drain");
        for (int n = 0; n < 40; n++) begin
            in_valid = 1'b1;
            in_dir   = 1'($urandom_range(0, 1));
            in_list  = rand_vec();
            in_amt   = 9'($urandom_range(0, 511));
            tick();
        end
        drain("t6_rand_drain");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
